// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file write-back types and constants
package rf_pkg;

    localparam int RF_D_WIDTH       = 32;
    localparam int RF_ADDRESS_WIDTH = 5;

    localparam logic [RF_ADDRESS_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [RF_ADDRESS_WIDTH-1:0] addr;
        logic [RF_D_WIDTH-1:0]       data;
    } rf_wr_t;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MUL = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with rotating priority pointer
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0]   N_W  = (PW+1)'(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_idx;
    logic          found;

    // Scan from the pointer upward, wrapping, and take the first active request.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            logic [PW:0]   sum;
            logic [PW-1:0] idx;
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (rst_n && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin write-back port arbiter with pending-write scoreboard
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int D_WIDTH       = RF_D_WIDTH,
    parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
    parameter int NUM_REQ       = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*D_WIDTH-1:0]       req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             wr_en,
    output logic [ADDRESS_WIDTH-1:0]         wr_addr,
    output logic [D_WIDTH-1:0]               din,
    input  logic                             sb_set,
    input  logic [ADDRESS_WIDTH-1:0]         sb_addr,
    input  logic [ADDRESS_WIDTH-1:0]         rs1_addr,
    input  logic [ADDRESS_WIDTH-1:0]         rs2_addr,
    output logic                             stall,
    output logic [(1<<ADDRESS_WIDTH)-1:0]    busy
);

    localparam int NREG = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_A = ADDRESS_WIDTH'(REG_ZERO);

    logic                     transfer;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [D_WIDTH-1:0]       sel_data;

    logic                     wr_en_q, wr_en_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [D_WIDTH-1:0]       din_q, din_d;
    logic [NREG-1:0]          busy_q, busy_d;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (transfer),
        .gnt     (req_ready)
    );

    assign transfer = |(req_valid & req_ready);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data = req_data[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

    // x0 writes are consumed here so the register file never sees them.
    always_comb begin
        wr_en_d   = transfer && (sel_addr != ZERO_A);
        wr_addr_d = transfer ? sel_addr : wr_addr_q;
        din_d     = transfer ? sel_data : din_q;
    end

    // Set is applied after clear so a newly issued writer of the same register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (sb_set && (sb_addr != ZERO_A)) begin
            busy_d[sb_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            din_q     <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign din     = din_q;
    assign busy    = busy_q;
    assign stall   = busy_q[rs1_addr] | busy_q[rs2_addr];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - table-driven self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   din;
    logic            sb_set;
    logic [AW-1:0]   sb_addr, rs1_addr, rs2_addr;
    logic            stall;
    logic [31:0]     busy;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .din(din), .sb_set(sb_set), .sb_addr(sb_addr), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .stall(stall), .busy(busy)
    );

    typedef struct {
        logic          rst;
        logic [2:0]    valid;
        logic [AW-1:0] a0, a1, a2;
        logic [DW-1:0] dat;
        logic          sbs;
        logic [AW-1:0] sba, rs1, rs2;
        logic [2:0]    exp_ready;
    } vec_t;

    typedef struct {
        logic   en;
        rf_wr_t w;
    } wr_exp_t;

    vec_t    vecs[$];
    wr_exp_t sb_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_busy;
    logic        m_en;
    logic [AW-1:0] m_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] valid,
                                input logic [AW-1:0] a0, a1, a2, input logic [DW-1:0] dat,
                                input logic sbs, input logic [AW-1:0] sba, rs1, rs2,
                                input logic [2:0] exp_ready);
        vec_t v;
        v.rst = rst; v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.dat = dat;
        v.sbs = sbs; v.sba = sba; v.rs1 = rs1; v.rs2 = rs2; v.exp_ready = exp_ready;
        return v;
    endfunction

    function automatic logic [DW-1:0] slice_data(input logic [DW-1:0] dat, input int i);
        if (i == WB_ALU) return dat ^ 32'h0F0F_0000;
        if (i == WB_LSU) return dat;
        return ~dat;
    endfunction

    task automatic apply(input vec_t v, input int r);
        wr_exp_t e;
        logic [AW-1:0] addrs[3];
        string tag;
        addrs[0] = v.a0; addrs[1] = v.a1; addrs[2] = v.a2;
        tag = $sformatf("row%0d", r);

        rst_n     = v.rst;
        req_valid = v.valid;
        req_addr  = {v.a2, v.a1, v.a0};
        req_data  = {slice_data(v.dat, 2), slice_data(v.dat, 1), slice_data(v.dat, 0)};
        sb_set    = v.sbs;
        sb_addr   = v.sba;
        rs1_addr  = v.rs1;
        rs2_addr  = v.rs2;

        @(negedge clk);
        chk({tag, " req_ready"}, 32'(req_ready), 32'(v.exp_ready));
        if (v.rst) begin
            chk({tag, " stall"}, 32'(stall), 32'(m_busy[v.rs1] | m_busy[v.rs2]));
        end

        e.en = 1'b0;
        e.w.addr = '0;
        e.w.data = '0;
        if (v.rst) begin
            for (int i = 0; i < NR; i++) begin
                if (v.exp_ready[i]) begin
                    e.en     = (addrs[i] != REG_ZERO);
                    e.w.addr = addrs[i];
                    e.w.data = slice_data(v.dat, i);
                end
            end
        end
        sb_q.push_back(e);

        @(posedge clk);
        if (!v.rst) begin
            m_busy = '0;
        end else begin
            if (m_en) m_busy[m_addr] = 1'b0;
            if (v.sbs && v.sba != 0) m_busy[v.sba] = 1'b1;
        end
        m_en   = e.en;
        m_addr = e.w.addr;

        #1;
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " wr_en"}, 32'(wr_en), 32'(e.en));
            if (e.en) begin
                chk({tag, " wr_addr"}, 32'(wr_addr), 32'(e.w.addr));
                chk({tag, " din"}, din, e.w.data);
            end
        end
        chk({tag, " busy"}, busy, m_busy);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        sb_set = 1'b0; sb_addr = '0; rs1_addr = '0; rs2_addr = '0;
        m_busy = '0; m_en = 1'b0; m_addr = '0;

        // reset with every requester asserting
        vecs.push_back(mk(0, 3'b111, 1, 2, 3, 32'h0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(0, 3'b111, 1, 2, 3, 32'h0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 0, 3'b000));
        // single request from the load unit
        vecs.push_back(mk(1, 3'b010, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 3'b010));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 0, 3'b000));
        // pointer back to 0, then continuous round-robin
        vecs.push_back(mk(0, 3'b111, 1, 2, 3, 32'h0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 3'b111, 1, 2, 3, 32'h1111_0001, 0, 0, 0, 0, 3'b001));
        vecs.push_back(mk(1, 3'b111, 1, 2, 3, 32'h1111_0002, 0, 0, 0, 0, 3'b010));
        vecs.push_back(mk(1, 3'b111, 1, 2, 3, 32'h1111_0003, 0, 0, 0, 0, 3'b100));
        vecs.push_back(mk(1, 3'b111, 1, 2, 3, 32'h1111_0004, 0, 0, 0, 0, 3'b001));
        vecs.push_back(mk(1, 3'b110, 0, 2, 3, 32'h1111_0004, 0, 0, 0, 0, 3'b010));
        vecs.push_back(mk(1, 3'b100, 0, 0, 3, 32'h1111_0004, 0, 0, 0, 0, 3'b100));
        // x0 write accepted but dropped, sb_set to x0 ignored
        vecs.push_back(mk(1, 3'b001, 0, 0, 0, 32'h0F0F_1234, 1, 0, 0, 0, 3'b001));
        // RAW hazard on x7
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 1, 7, 7, 0, 3'b000));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 0, 0, 7, 0, 3'b000));
        vecs.push_back(mk(1, 3'b001, 7, 0, 0, 32'h0000_0077, 0, 0, 7, 0, 3'b001));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 0, 0, 7, 0, 3'b000));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 0, 0, 7, 0, 3'b000));
        // commit of x9 coincides with a new issue to x9
        vecs.push_back(mk(1, 3'b010, 0, 9, 0, 32'h0000_0099, 1, 9, 0, 0, 3'b010));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 1, 9, 0, 9, 3'b000));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 9, 3'b000));
        // mid-operation reset drops the pending transfer and busy bits
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 1, 12, 12, 0, 3'b000));
        vecs.push_back(mk(0, 3'b100, 0, 0, 12, 32'hCAFE_0012, 0, 0, 12, 0, 3'b000));
        vecs.push_back(mk(1, 3'b111, 4, 5, 6, 32'h2222_0001, 0, 0, 12, 0, 3'b001));
        vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 0, 0, 0, 0, 3'b000));

        @(posedge clk);
        #1;
        for (int r = 0; r < vecs.size(); r++) begin
            apply(vecs[r], r);
        end

        // idle hold: wr_addr/din keep the last granted write (x4 / ALU data)
        chk("hold wr_addr", 32'(wr_addr), 32'd4);
        chk("hold din", din, slice_data(32'h2222_0001, WB_ALU));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
